// File: rtl/bitstream_serial_tx_if.sv
// Word handshake bundle for the serial configuration transmitter.
// The producer drives word_data/word_valid; the transmitter drives word_ready.
interface bitstream_serial_tx_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/bitstream_serial_tx.sv
// Host-side serializer for the fabric's two-wire configuration port.
// Words arrive over a valid/ready handshake and leave MSB first on s_data,
// qualified by s_clk rising edges. One word is in flight in the shift
// register while a second may wait in the holding register, so consecutive
// words stream with no idle bit period between them.
module bitstream_serial_tx #(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    bitstream_serial_tx_if.slave  word_if,
    output logic                  s_clk,
    output logic                  s_data,
    output logic                  busy
);

    localparam int BCNT_W = (WORD_W > 1)  ? $clog2(WORD_W)  : 1;
    localparam int DCNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   sh_q, sh_d;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic                hold_v_q, hold_v_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                s_clk_d, s_data_d, busy_d;

    logic                hs;
    logic                div_end;
    logic                last_bit;

    // Ready depends only on the hold flag register, never on word_valid.
    assign word_if.word_ready = !hold_v_q;
    assign hs       = word_if.word_valid && !hold_v_q;
    assign div_end  = (dcnt_q == DCNT_W'(CLK_DIV - 1));
    assign last_bit = (bcnt_q == BCNT_W'(WORD_W - 1));

    // State, datapath and output registers; reset discards any word in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            bcnt_q   <= '0;
            dcnt_q   <= '0;
            s_clk    <= 1'b0;
            s_data   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            bcnt_q   <= bcnt_d;
            dcnt_q   <= dcnt_d;
            s_clk    <= s_clk_d;
            s_data   <= s_data_d;
            busy     <= busy_d;
        end
    end

    // Next-state, datapath and output decode for the LOW/HIGH bit phases.
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        bcnt_d   = bcnt_q;
        dcnt_d   = dcnt_q;
        s_clk_d  = s_clk;
        s_data_d = s_data;
        busy_d   = busy;

        // While a word is shifting, an accepted word parks in the holding
        // register; the last-bit reload below may override this when it
        // takes the word straight into the shift register instead.
        if (state_q != IDLE && hs) begin
            hold_d   = word_if.word_data;
            hold_v_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hs) begin
                    sh_d     = word_if.word_data;
                    s_data_d = word_if.word_data[WORD_W-1];
                    s_clk_d  = 1'b0;
                    busy_d   = 1'b1;
                    bcnt_d   = '0;
                    dcnt_d   = '0;
                    state_d  = LOW;
                end
            end

            LOW: begin
                if (div_end) begin
                    dcnt_d  = '0;
                    s_clk_d = 1'b1;
                    state_d = HIGH;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end

            HIGH: begin
                if (div_end) begin
                    dcnt_d  = '0;
                    s_clk_d = 1'b0;
                    if (!last_bit) begin
                        bcnt_d   = bcnt_q + BCNT_W'(1);
                        sh_d     = {sh_q[WORD_W-2:0], 1'b0};
                        s_data_d = sh_q[WORD_W-2];
                        state_d  = LOW;
                    end else if (hold_v_q) begin
                        // Buffered word drains into the shifter; a word
                        // accepted on this edge stays buffered.
                        sh_d     = hold_q;
                        s_data_d = hold_q[WORD_W-1];
                        hold_v_d = hs;
                        bcnt_d   = '0;
                        state_d  = LOW;
                    end else if (hs) begin
                        // Hold empty: bypass it so the stream has no gap.
                        sh_d     = word_if.word_data;
                        s_data_d = word_if.word_data[WORD_W-1];
                        hold_d   = hold_q;
                        hold_v_d = 1'b0;
                        bcnt_d   = '0;
                        state_d  = LOW;
                    end else begin
                        s_data_d = 1'b0;
                        busy_d   = 1'b0;
                        bcnt_d   = '0;
                        state_d  = IDLE;
                    end
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                s_clk_d  = 1'b0;
                s_data_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bitstream_serial_tx.sv
// Bench for bitstream_serial_tx: two instances (CLK_DIV=2 and CLK_DIV=1)
// checked every cycle against a position-in-stream model, with a receiver
// that samples s_data on s_clk rising edges and literal expectations per test.
module tb_bitstream_serial_tx;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic [W-1:0]  wd   [2];
    logic          wv   [2];
    logic          rdy  [2];
    logic          sclk [2];
    logic          sdat [2];
    logic          bsy  [2];

    bitstream_serial_tx_if #(.WORD_W(W)) bus0 ();
    bitstream_serial_tx_if #(.WORD_W(W)) bus1 ();

    assign bus0.word_data  = wd[0];
    assign bus0.word_valid = wv[0];
    assign rdy[0]          = bus0.word_ready;
    assign bus1.word_data  = wd[1];
    assign bus1.word_valid = wv[1];
    assign rdy[1]          = bus1.word_ready;

    bitstream_serial_tx #(.CLK_DIV(2), .WORD_W(W)) dut0 (
        .CLK(clk), .RST(rst), .word_if(bus0.slave),
        .s_clk(sclk[0]), .s_data(sdat[0]), .busy(bsy[0])
    );

    bitstream_serial_tx #(.CLK_DIV(1), .WORD_W(W)) dut1 (
        .CLK(clk), .RST(rst), .word_if(bus1.slave),
        .s_clk(sclk[1]), .s_data(sdat[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: a word in flight is a position in a 2*DIV*W-cycle stream.
    bit           act    [2];
    int           pos    [2];
    logic [W-1:0] cur    [2];
    logic [W-1:0] pend_w [2];
    bit           pend_v [2];
    bit           acc_f  [2];
    logic [W-1:0] exp_q0 [$];

    // Receiver / measurement state.
    int           edges    [2];
    int           bcycles  [2];
    int           min_iv   [2];
    int           max_iv   [2];
    int           last_rise[2];
    int           rxbits   [2];
    logic [W-1:0] rxw      [2];
    logic         prev_sclk[2];

    function automatic int div_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d: got=%h expected=%h at %0t", nm, k, got, want, $time);
        end
    endtask

    task automatic model_step(input int k);
        bit acc;
        int per;
        per = 2 * div_of(k);
        acc = wv[k] && !pend_v[k];
        acc_f[k] = 1'b0;
        if (rst) begin
            act[k] = 0; pos[k] = 0; pend_v[k] = 0;
            if (k == 0) exp_q0.delete();
            return;
        end
        acc_f[k] = acc;
        if (acc && k == 0) exp_q0.push_back(wd[k]);
        if (act[k]) begin
            pos[k]++;
            if (pos[k] == W * per) begin
                pos[k] = 0;
                if (pend_v[k]) begin
                    cur[k] = pend_w[k];
                    pend_v[k] = 0;
                end else if (acc) begin
                    cur[k] = wd[k];
                end else begin
                    act[k] = 0;
                end
            end else if (acc) begin
                pend_w[k] = wd[k];
                pend_v[k] = 1;
            end
        end else if (acc) begin
            act[k] = 1;
            pos[k] = 0;
            cur[k] = wd[k];
        end
    endtask

    task automatic compare_and_monitor(input int k);
        int   per;
        logic e_clk, e_dat, e_busy;
        per = 2 * div_of(k);
        if (act[k]) begin
            e_clk  = (pos[k] % per) >= div_of(k);
            e_dat  = cur[k][W - 1 - pos[k] / per];
            e_busy = 1'b1;
        end else begin
            e_clk = 1'b0; e_dat = 1'b0; e_busy = 1'b0;
        end
        chk("s_clk",      k, sclk[k], e_clk);
        chk("s_data",     k, sdat[k], e_dat);
        chk("busy",       k, bsy[k],  e_busy);
        chk("word_ready", k, rdy[k],  !pend_v[k]);

        if (rst) begin
            rxbits[k] = 0;
            prev_sclk[k] = 1'b0;
            return;
        end
        if (bsy[k]) bcycles[k]++;
        if (sclk[k] && !prev_sclk[k]) begin
            edges[k]++;
            rxw[k] = {rxw[k][W-2:0], sdat[k]};
            rxbits[k]++;
            if (last_rise[k] >= 0) begin
                if (cyc - last_rise[k] < min_iv[k]) min_iv[k] = cyc - last_rise[k];
                if (cyc - last_rise[k] > max_iv[k]) max_iv[k] = cyc - last_rise[k];
            end
            last_rise[k] = cyc;
            if (rxbits[k] == W) begin
                rxbits[k] = 0;
                if (k == 0) begin
                    if (exp_q0.size() == 0) chk("rx_unexpected_word", k, rxw[k], 32'hx);
                    else chk("rx_word_order", k, rxw[k], exp_q0.pop_front());
                end
            end
        end
        prev_sclk[k] = sclk[k];
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        for (int k = 0; k < 2; k++) compare_and_monitor(k);
    endtask

    task automatic clear_mon(input int k);
        edges[k] = 0; bcycles[k] = 0; min_iv[k] = 1 << 30; max_iv[k] = 0;
        last_rise[k] = -1; rxbits[k] = 0; rxw[k] = '0;
    endtask

    task automatic send(input int k, input logic [W-1:0] w);
        int n;
        n = 0;
        wv[k] = 1'b1;
        wd[k] = w;
        do begin tick(); n++; end while (!acc_f[k] && n < 1000);
        wv[k] = 1'b0;
        chk("accept_timeout", k, acc_f[k], 1);
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((act[k] || pend_v[k] || bsy[k]) && n < 2000) begin tick(); n++; end
        chk("idle_timeout", k, (n < 2000), 1);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            wv[k] = 1'b0; wd[k] = '0; act[k] = 0; pos[k] = 0;
            pend_v[k] = 0; acc_f[k] = 0; prev_sclk[k] = 1'b0; clear_mon(k);
        end
        rst = 1'b1;
        tick();
        chk("reset_ready", 0, rdy[0], 1);
        chk("reset_busy",  0, bsy[0], 0);
        chk("reset_sclk",  1, sclk[1], 0);
        rst = 1'b0;
        tick();

        // Single word at CLK_DIV=2.
        clear_mon(0);
        send(0, 32'hA500_0001);
        wait_idle(0);
        chk("single_edges",  0, edges[0],   32);
        chk("single_word",   0, rxw[0],     32'hA500_0001);
        chk("single_busy",   0, bcycles[0], 128);
        chk("single_per_lo", 0, min_iv[0],  4);
        chk("single_per_hi", 0, max_iv[0],  4);
        chk("single_sdata0", 0, sdat[0],    0);

        // Back-to-back words.
        clear_mon(0);
        wv[0] = 1'b1; wd[0] = 32'hDEAD_BEEF;
        tick();
        chk("b2b_acc1", 0, acc_f[0], 1);
        wd[0] = 32'h1234_5678;
        tick();
        chk("b2b_acc2", 0, acc_f[0], 1);
        wv[0] = 1'b0;
        chk("b2b_ready_low", 0, rdy[0], 0);
        n = 0;
        while (!rdy[0] && n < 1000) begin tick(); n++; end
        chk("b2b_ready_return", 0, n, 127);
        wait_idle(0);
        chk("b2b_edges",  0, edges[0],   64);
        chk("b2b_busy",   0, bcycles[0], 256);
        chk("b2b_gap",    0, max_iv[0],  4);

        // Backpressure with three queued words.
        clear_mon(0);
        wv[0] = 1'b1; wd[0] = 32'h1111_0001;
        tick();
        wd[0] = 32'h2222_0002;
        tick();
        wd[0] = 32'h3333_0003;
        tick();
        chk("bp_stall", 0, acc_f[0], 0);
        n = 0;
        do begin tick(); n++; end while (!acc_f[0] && n < 1000);
        wv[0] = 1'b0;
        chk("bp_stall_len", 0, n, 127);
        wait_idle(0);
        chk("bp_edges", 0, edges[0], 96);
        chk("bp_gap",   0, max_iv[0], 4);

        // Reset mid-word.
        clear_mon(0);
        send(0, 32'hFFFF_FFFF);
        n = 0;
        while (edges[0] < 10 && n < 1000) begin tick(); n++; end
        chk("rst_reach_10", 0, edges[0], 10);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_sclk",  0, sclk[0], 0);
        chk("rst_async_sdata", 0, sdat[0], 0);
        chk("rst_async_busy",  0, bsy[0],  0);
        chk("rst_async_ready", 0, rdy[0],  1);
        tick();
        rst = 1'b0;
        tick();
        clear_mon(0);
        send(0, 32'h0000_000F);
        wait_idle(0);
        chk("post_rst_edges", 0, edges[0], 32);
        chk("post_rst_word",  0, rxw[0],   32'h0000_000F);

        // CLK_DIV=1 corner.
        clear_mon(1);
        send(1, 32'h8000_0000);
        wait_idle(1);
        chk("div1_edges",  1, edges[1],   32);
        chk("div1_word",   1, rxw[1],     32'h8000_0000);
        chk("div1_busy",   1, bcycles[1], 64);
        chk("div1_period", 1, max_iv[1],  2);

        // Handshake exactly on the final HIGH-phase edge with hold empty.
        clear_mon(0);
        send(0, 32'h0F0F_0F0F);
        n = 0;
        while (pos[0] != 127 && n < 1000) begin tick(); n++; end
        wv[0] = 1'b1; wd[0] = 32'h3C3C_3C3C;
        tick();
        wv[0] = 1'b0;
        chk("last_edge_acc",   0, acc_f[0], 1);
        chk("last_edge_ready", 0, rdy[0],   1);
        chk("last_edge_busy",  0, bsy[0],   1);
        wait_idle(0);
        chk("last_edge_edges", 0, edges[0], 64);
        chk("last_edge_gap",   0, max_iv[0], 4);

        // Randomized traffic on both instances; source holds data while stalled.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!wv[k] || acc_f[k]) begin
                    wv[k] = ($urandom_range(0, 3) == 0);
                    wd[k] = $urandom;
                end
            end
            tick();
        end
        wv[0] = 1'b0; wv[1] = 1'b0;
        wait_idle(0);
        wait_idle(1);
        chk("scoreboard_drained", 0, exp_q0.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bitstream_serial_tx.md
Name: bitstream_serial_tx

Overview:
- Host-side serializer for the fabric's two-wire serial configuration port (s_clk/s_data).
- Accepts 32-bit configuration words over a valid/ready handshake and shifts them out MSB first as an s_clk/s_data bit stream.
- Drives the eFPGA_top s_clk and s_data inputs in system-level benches and in the board-side loader.
- Holds one word in flight plus one buffered word, so consecutive words stream with no gap between them.

Parameters:
- CLK_DIV, 4: CLK cycles per s_clk half-period. Must be at least 1.
- WORD_W, 32: configuration word width in bits.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- word_data  input  WORD_W  configuration word to send.
- word_valid  input  1  word_data is valid.
- word_ready  output  1  block can accept a word this cycle.
- s_clk  output  1  serial configuration clock to the fabric.
- s_data  output  1  serial configuration data to the fabric.
- busy  output  1  a word is currently being shifted out.

Behaviour:
- State: shift register sh[WORD_W-1:0]; holding register hold plus flag hold_v; bit counter bcnt (clog2(WORD_W) bits); divider counter dcnt; FSM states IDLE, LOW, HIGH.
- s_clk, s_data and busy are registered outputs. word_ready = !hold_v, decoded from a register only, with no combinational path from word_valid.
- Reset (asynchronous, immediate): state IDLE, s_clk=0, s_data=0, busy=0, hold_v=0 (so word_ready=1), bcnt=0, dcnt=0. Any in-flight or buffered words are discarded. Reset applied mid-word truncates the word: no further s_clk edges are produced.
- A handshake occurs on a CLK edge where word_valid && word_ready.
- IDLE + handshake:
  - sh is loaded with word_data directly; the hold register is bypassed.
  - State goes to LOW; s_data=word_data[WORD_W-1]; s_clk=0; busy=1; bcnt=0; dcnt=0.
- Non-IDLE + handshake: hold<=word_data, hold_v<=1.
- LOW state: s_clk=0 for CLK_DIV cycles. When dcnt reaches CLK_DIV-1: dcnt<=0, state HIGH, s_clk<=1. s_data does not change.
- HIGH state: s_clk=1 for CLK_DIV cycles. When dcnt reaches CLK_DIV-1, s_clk<=0 and:
  - If bcnt < WORD_W-1: bcnt++, sh shifts left by 1, s_data<=next bit, state LOW.
  - Else if hold_v, or a handshake occurs on this same edge: load sh from hold (or from word_data if hold is empty), clear hold_v, bcnt<=0, s_data<=new MSB, state LOW. There are no idle cycles between words.
  - Else: state IDLE, s_data<=0, busy<=0.
- Simultaneous handshake and hold-to-sh transfer on the same edge: word_data goes to sh only if hold_v was 0. Otherwise hold drains into sh and hold<=word_data, with hold_v staying 1. No word may be lost or duplicated.
- s_data is stable for the whole HIGH phase. The receiver samples on the s_clk rising edge. Setup and hold are each CLK_DIV CLK cycles.
- Bit period is 2*CLK_DIV cycles. One word takes WORD_W*2*CLK_DIV cycles of busy.
- word_valid with word_ready=0: no transfer. word_data is ignored and the source must hold it.

Test Plan:
- Single word, CLK_DIV=2: send 0xA5000001 from idle.
  - Exactly 32 s_clk rising edges.
  - s_clk period is 4 CLK cycles.
  - Bits sampled on rising edges read 0xA5000001, MSB first.
  - busy is high for exactly 128 cycles, then s_clk=0, s_data=0.
- Back-to-back: offer 0xDEADBEEF, then 0x12345678 the following cycle.
  - Both are accepted; word_ready drops after the second accept.
  - 64 contiguous rising edges with no gap and the correct data.
  - word_ready returns to 1 on the edge where the second word moves into sh.
- Backpressure: hold word_valid high with three words queued.
  - The third word stalls until the first word finishes.
  - All three words appear in order; none is dropped or duplicated.
- Reset mid-word: assert RST after 10 bits of 0xFFFFFFFF.
  - s_clk, s_data and busy are 0 immediately, without waiting for a CLK edge; word_ready=1.
  - After release, sending 0x0000000F produces exactly 32 edges with the correct data.
- CLK_DIV=1 corner: send 0x80000000.
  - s_clk toggles every cycle.
  - The first sampled bit is 1 and the remaining 31 are 0.
  - busy lasts 64 cycles.
- Handshake on the last-bit edge: present a new word exactly on the final HIGH-phase edge with hold empty.
  - The word loads straight into sh and there is no gap in s_clk.
